hamming_serial_rx: RTL and testbench

HAMMING_SERIAL_RX -- requirements
Module: hamming_serial_rx

---
 rtl/hamming_serial_rx.sv | 123 ++++++++++++
 tb/tb_hamming_serial_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_rx.sv
// Serial receiver for extended Hamming(7,4)+p0 frames. It corrects single-bit errors,
// flags double-bit errors, and presents a one-deep output with saturating error statistics.
module hamming_serial_rx #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             sync,
    input  logic             clear_stats,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic             out_valid,
    output logic             err_corr,
    output logic             err_uncorr,
    output logic             overrun,
    output logic             busy,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    // state | meaning
    // IDLE  | no bits of a frame held
    // SHIFT | 1..7 bits of a partial frame held
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] code;
    logic [7:0] cw;
    logic [2:0] syn;
    logic       par;
    logic [6:0] fixed;
    logic [3:0] dec_data;
    logic       dec_corr, dec_uncorr;
    logic       frame_done, load, drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (sync)
            state_nxt = bit_valid ? SHIFT : IDLE;
        else if (bit_valid)
            state_nxt = (bit_cnt == 3'd7) ? IDLE : SHIFT;
    end

    assign busy = (state == SHIFT);

    // code[i] holds c(i+1); the final bit p0 is taken straight from bit_in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= 3'd0;
            code    <= 7'd0;
        end else if (sync) begin
            bit_cnt <= bit_valid ? 3'd1 : 3'd0;
            code    <= {6'd0, bit_valid & bit_in};
        end else if (bit_valid) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt != 3'd7)
                code[bit_cnt] <= bit_in;
        end
    end

    assign frame_done = bit_valid && !sync && (bit_cnt == 3'd7);
    assign cw         = {bit_in, code};

    always_comb begin
        syn[0]     = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1]     = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2]     = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        par        = ^cw;
        fixed      = cw[6:0];
        if (par && (syn != 3'd0))
            fixed = cw[6:0] ^ (7'd1 << (syn - 3'd1));
        dec_data   = {fixed[6], fixed[5], fixed[4], fixed[2]};
        dec_corr   = par;
        dec_uncorr = (syn != 3'd0) && !par;
    end

    assign load = frame_done && (!out_valid || out_ready);
    assign drop = frame_done && out_valid && !out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= 4'd0;
            out_valid  <= 1'b0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
        end else if (load) begin
            data_out   <= dec_data;
            out_valid  <= 1'b1;
            err_corr   <= dec_corr;
            err_uncorr <= dec_uncorr;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // a clear and a classification in the same cycle leave the new event counted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= (overrun & ~clear_stats) | drop;
            if (clear_stats)
                corr_cnt <= CNT_W'(load && dec_corr);
            else if (load && dec_corr && (corr_cnt != '1))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (clear_stats)
                uncorr_cnt <= CNT_W'(load && dec_uncorr);
            else if (load && dec_uncorr && (uncorr_cnt != '1))
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: a codeword-distance reference model feeds a
// scoreboard of the nibble expected in data_out, alongside model counters and overrun.
module tb_hamming_serial_rx;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             bit_valid = 1'b0, bit_in = 1'b0, sync = 1'b0;
    logic             clear_stats = 1'b0, out_ready = 1'b0;
    logic [3:0]       data_out;
    logic             out_valid, err_corr, err_uncorr, overrun, busy;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

    int checks = 0;
    int errors = 0;

    logic [5:0]       sb[$];      // {uncorr, corr, data}
    int               exp_corr = 0, exp_unc = 0;
    logic             exp_ovr = 1'b0;
    localparam int    SAT = (1 << CNT_W) - 1;

    hamming_serial_rx #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in), .sync(sync),
        .clear_stats(clear_stats), .out_ready(out_ready), .data_out(data_out),
        .out_valid(out_valid), .err_corr(err_corr), .err_uncorr(err_uncorr),
        .overrun(overrun), .busy(busy), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [0:7] enc(input logic [3:0] d);
        logic [0:7] s;
        s[2] = d[0]; s[4] = d[1]; s[5] = d[2]; s[6] = d[3];
        s[0] = d[0] ^ d[1] ^ d[3];
        s[1] = d[0] ^ d[2] ^ d[3];
        s[3] = d[1] ^ d[2] ^ d[3];
        s[7] = s[0] ^ s[1] ^ s[2] ^ s[3] ^ s[4] ^ s[5] ^ s[6];
        return s;
    endfunction

    // nearest-codeword decode: distance 0 clean, 1 corrected, otherwise raw + uncorrectable
    function automatic logic [5:0] model(input logic [0:7] s);
        logic [0:7] diff;
        for (int k = 0; k < 16; k++) begin
            diff = enc(4'(k)) ^ s;
            if ($countones(diff) == 0) return {2'b00, 4'(k)};
            if ($countones(diff) == 1) return {2'b01, 4'(k)};
        end
        return {2'b10, s[6], s[5], s[4], s[2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(out_valid), 32'(sb.size() > 0));
        if (sb.size() > 0) begin
            chk({tag, ".data"},   32'(data_out),   32'(sb[0][3:0]));
            chk({tag, ".corr"},   32'(err_corr),   32'(sb[0][4]));
            chk({tag, ".uncorr"}, 32'(err_uncorr), 32'(sb[0][5]));
        end
        chk({tag, ".corr_cnt"},   32'(corr_cnt),   32'(exp_corr));
        chk({tag, ".uncorr_cnt"}, 32'(uncorr_cnt), 32'(exp_unc));
        chk({tag, ".overrun"},    32'(overrun),    32'(exp_ovr));
        chk({tag, ".busy"},       32'(busy),       32'd0);
    endtask

    // sends a frame in arrival order s[0]=c1 .. s[7]=p0; inputs change just after negedge
    task automatic frame(input logic [0:7] s, input bit rdy_last, input bit clr_last,
                         input int gap, input bit sync_first);
        logic [5:0] m;
        bit load;
        for (int i = 0; i < 8; i++) begin
            if (i == 3 && gap > 0) begin
                bit_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            bit_valid   = 1'b1;
            bit_in      = s[i];
            sync        = (i == 0) && sync_first;
            out_ready   = (i == 7) && rdy_last;
            clear_stats = (i == 7) && clr_last;
            @(negedge clk);
        end
        bit_valid = 1'b0; sync = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
        load = (sb.size() == 0) || rdy_last;
        m = model(s);
        if (clr_last) begin
            exp_corr = 0; exp_unc = 0;
            exp_ovr  = !load;
        end else if (!load) begin
            exp_ovr = 1'b1;
        end
        if (load) begin
            if (sb.size() > 0) void'(sb.pop_front());
            sb.push_back(m);
            if (m[4] && exp_corr < SAT) exp_corr++;
            if (m[5] && exp_unc < SAT)  exp_unc++;
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
        chk({tag, ".consumed"}, 32'(out_valid), 32'd0);
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bit_valid = 1'b0;
    endtask

    initial begin
        logic [0:7] s;
        logic [3:0] d;
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.data_out", 32'(data_out), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        frame(8'b1010_1010, 0, 0, 0, 0);
        check_all("clean");
        chk("clean.data_lit", 32'(data_out), 32'hB);
        consume("clean");

        frame(8'b1010_0010, 0, 0, 2, 0);
        check_all("c5_flip");
        chk("c5_flip.cnt_lit", 32'(corr_cnt), 32'd1);
        consume("c5_flip");

        frame(8'b0110_1010, 0, 0, 0, 0);
        check_all("c1c2_flip");
        chk("c1c2_flip.data_lit", 32'(data_out), 32'hB);
        consume("c1c2_flip");

        frame(8'b1010_1011, 0, 0, 0, 0);
        check_all("p0_flip");
        consume("p0_flip");

        frame(8'b1010_1010, 0, 0, 0, 0);
        frame(8'b0110_0110, 0, 0, 0, 0);
        check_all("overrun_drop");
        chk("overrun_drop.lit", 32'(data_out), 32'hB);
        frame(8'b0110_0110, 1, 0, 0, 0);
        check_all("load_on_ready");
        chk("load_on_ready.lit", 32'(data_out), 32'hD);
        consume("load_on_ready");

        partial(3);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        chk("sync.busy", 32'(busy), 32'd0);
        frame(8'b1010_1010, 0, 0, 0, 0);
        check_all("after_sync");
        consume("after_sync");
        partial(5);
        frame(8'b0110_0110, 0, 0, 0, 1);
        check_all("sync_with_bit");
        consume("sync_with_bit");

        frame(8'b1010_1010, 0, 0, 0, 0);
        partial(5);
        chk("midframe.busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        sb.delete(); exp_corr = 0; exp_unc = 0; exp_ovr = 1'b0;
        check_all("async_reset");
        chk("async_reset.data_out", 32'(data_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        frame(8'b0110_0110, 0, 0, 0, 0);
        check_all("post_reset");
        consume("post_reset");

        for (int n = 0; n < SAT + 2; n++) begin
            d = 4'($urandom_range(0, 15));
            s = enc(d);
            s[$urandom_range(0, 7)] ^= 1'b1;
            frame(s, 1, 0, 0, 0);
            chk("sat_loop.data", 32'(data_out), 32'(d));
        end
        check_all("saturated");
        chk("saturated.lit", 32'(corr_cnt), 32'(SAT));

        frame(8'b0110_1010, 0, 0, 0, 0);
        check_all("drop_after_sat");
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        exp_corr = 0; exp_unc = 0; exp_ovr = 1'b0;
        check_all("cleared");

        frame(8'b1010_0010, 1, 1, 0, 0);
        check_all("clear_with_corr");
        chk("clear_with_corr.lit", 32'(corr_cnt), 32'd1);
        consume("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
